// File: rtl/mem_arbiter.sv
// Arbiter/sequencer that serialises fetch and load/store requests onto a byte-wide RAM port.
// Optional: define MEM_IO_STALL_EN to hold writes to the IO window while io_buffer_full is set.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  // state | meaning
  // IDLE  | port free, arbitrating (ls over fetch)
  // RD    | issuing byte addresses and collecting mem_din
  // WR    | issuing byte writes
  // DONE  | ready pulse cycle, requests not sampled
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              src_ls, src_ls_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [1:0]        nlast, nlast_nxt;
  logic              sgn, sgn_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic [31:0]       rbuf, rbuf_nxt;
  logic [ADDR_W-1:0] mem_a_nxt;
  logic [7:0]        mem_dout_nxt;
  logic              mem_wr_nxt;
  logic              if_ready_nxt, ls_ready_nxt;
  logic [31:0]       if_data_nxt, ls_rdata_nxt;

  logic [2:0]        cnt1;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] addr_k1;

`ifdef MEM_IO_STALL_EN
  logic stalled, stalled_nxt;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
`endif

  assign cnt1    = cnt + 3'd1;
  assign cap_idx = cnt[1:0] - 2'd1;
  assign addr_k1 = addr + ADDR_W'(cnt1);

  function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] nl,
                                         input logic s);
    case (nl)
      2'd0:    extend = {{24{s & b[7]}}, b[7:0]};
      2'd1:    extend = {{16{s & b[15]}}, b[15:0]};
      default: extend = b;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      src_ls   <= 1'b0;
      addr     <= '0;
      nlast    <= '0;
      sgn      <= 1'b0;
      wdata    <= '0;
      rbuf     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
`ifdef MEM_IO_STALL_EN
      stalled  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      src_ls   <= src_ls_nxt;
      addr     <= addr_nxt;
      nlast    <= nlast_nxt;
      sgn      <= sgn_nxt;
      wdata    <= wdata_nxt;
      rbuf     <= rbuf_nxt;
      mem_a    <= mem_a_nxt;
      mem_dout <= mem_dout_nxt;
      mem_wr   <= mem_wr_nxt;
      if_ready <= if_ready_nxt;
      ls_ready <= ls_ready_nxt;
      if_data  <= if_data_nxt;
      ls_rdata <= ls_rdata_nxt;
`ifdef MEM_IO_STALL_EN
      stalled  <= stalled_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    src_ls_nxt   = src_ls;
    addr_nxt     = addr;
    nlast_nxt    = nlast;
    sgn_nxt      = sgn;
    wdata_nxt    = wdata;
    rbuf_nxt     = rbuf;
    mem_a_nxt    = mem_a;
    mem_dout_nxt = mem_dout;
    mem_wr_nxt   = 1'b0;
    if_ready_nxt = 1'b0;
    ls_ready_nxt = 1'b0;
    if_data_nxt  = if_data;
    ls_rdata_nxt = ls_rdata;
`ifdef MEM_IO_STALL_EN
    stalled_nxt  = stalled;
`endif

    case (state)
      IDLE: begin
        if (ls_req) begin
          src_ls_nxt = 1'b1;
          addr_nxt   = ls_addr;
          nlast_nxt  = (ls_size == 2'd0) ? 2'd0 : (ls_size == 2'd1) ? 2'd1 : 2'd3;
          sgn_nxt    = ls_signed;
          wdata_nxt  = ls_wdata;
          cnt_nxt    = '0;
          rbuf_nxt   = '0;
          mem_a_nxt  = ls_addr;
          if (ls_we) begin
            state_nxt    = WR;
            mem_dout_nxt = ls_wdata[7:0];
            mem_wr_nxt   = 1'b1;
          end else begin
            state_nxt = RD;
          end
        end else if (if_req && !if_flush) begin
          src_ls_nxt = 1'b0;
          addr_nxt   = if_addr;
          nlast_nxt  = 2'd3;
          sgn_nxt    = 1'b0;
          cnt_nxt    = '0;
          rbuf_nxt   = '0;
          mem_a_nxt  = if_addr;
          state_nxt  = RD;
        end
      end

      RD: begin
        if (!src_ls && if_flush) begin
          state_nxt = IDLE;
        end else begin
          // RAM has one cycle of read latency, so byte k lands two edges after its address
          if (cnt != 3'd0)
            rbuf_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
          if (cnt < {1'b0, nlast})
            mem_a_nxt = addr_k1;
          if (cnt == {1'b0, nlast} + 3'd1) begin
            state_nxt = DONE;
            if (src_ls) begin
              ls_rdata_nxt = extend(rbuf_nxt, nlast, sgn);
              ls_ready_nxt = 1'b1;
            end else begin
              if_data_nxt  = rbuf_nxt;
              if_ready_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt1;
          end
        end
      end

      WR: begin
`ifdef MEM_IO_STALL_EN
        if (mem_a[17:16] == 2'b11 && io_buffer_full) begin
          stalled_nxt = 1'b1;
        end else if (stalled) begin
          mem_wr_nxt  = 1'b1;
          stalled_nxt = 1'b0;
        end else
`endif
        if (cnt < {1'b0, nlast}) begin
          cnt_nxt      = cnt1;
          mem_a_nxt    = addr_k1;
          mem_dout_nxt = wdata[{cnt1[1:0], 3'b000} +: 8];
          mem_wr_nxt   = 1'b1;
        end else begin
          ls_ready_nxt = 1'b1;
          state_nxt    = DONE;
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus arbitration, flush and reset sequences.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_signed, ls_ready;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM model: one cycle read latency, writes on the edge while mem_wr is high
  logic [7:0] ram [0:1023];
  logic       tb_wr;
  logic [9:0] tb_wa;
  logic [7:0] tb_wd;
  always @(posedge clk) begin
    if (tb_wr) ram[tb_wa] <= tb_wd;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  typedef struct {
    logic        fetch;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic        src_ls;
    logic        has_data;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[15];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_cnt = 0;

  function automatic vec_t mk(input logic f, input logic we, input logic [1:0] sz,
                              input logic s, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] e, input int lat);
    vec_t v;
    v.fetch = f; v.we = we; v.size = sz; v.sgn = s;
    v.addr = a; v.wdata = wd; v.exp = e; v.lat = lat;
    return v;
  endfunction

  function automatic int nbytes(input vec_t v);
    if (v.fetch) return 4;
    if (v.size == 2'd0) return 1;
    if (v.size == 2'd1) return 2;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // advance to the next falling edge and score any ready pulse against the queue
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (if_ready || ls_ready) begin
      rdy_cnt++;
      chk("single_ready", {31'b0, if_ready & ls_ready}, 32'd0);
      chk("sb_nonempty", {31'b0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ready_source", {31'b0, ls_ready}, {31'b0, e.src_ls});
        if (e.has_data) chk("read_data", e.src_ls ? ls_rdata : if_data, e.data);
      end
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    tb_wa = a; tb_wd = d; tb_wr = 1'b1;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  n;
    bit  seen;
    sb_t e;
    n = nbytes(v);
    seen = 1'b0;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_signed = v.sgn;
      ls_addr = v.addr; ls_wdata = v.wdata;
    end
    e.src_ls = !v.fetch;
    e.has_data = v.fetch || !v.we;
    e.data = v.exp;
    sb_q.push_back(e);
    for (int j = 0; j < 16 && !seen; j++) begin
      tick();
      if (j < n) begin
        chk($sformatf("v%0d_mem_a_b%0d", id, j), mem_a, v.addr + 32'(j));
        chk($sformatf("v%0d_mem_wr_b%0d", id, j), {31'b0, mem_wr}, {31'b0, v.we});
        if (v.we)
          chk($sformatf("v%0d_mem_dout_b%0d", id, j), {24'b0, mem_dout},
              {24'b0, 8'(v.wdata >> (8 * j))});
      end
      if (if_ready || ls_ready) begin
        seen = 1'b1;
        chk($sformatf("v%0d_latency", id), 32'(j), 32'(v.lat));
        chk($sformatf("v%0d_wr_at_ready", id), {31'b0, mem_wr}, 32'd0);
      end
    end
    chk($sformatf("v%0d_ready_seen", id), {31'b0, seen}, 32'd1);
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    chk($sformatf("v%0d_ready_cleared", id), {30'b0, if_ready, ls_ready}, 32'd0);
    chk($sformatf("v%0d_idle_mem_a", id), mem_a, v.addr + 32'(n - 1));
    chk($sformatf("v%0d_idle_mem_wr", id), {31'b0, mem_wr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  r0;
    sb_t e;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_signed = 1'b0;
    ls_addr = '0; ls_wdata = '0; io_buffer_full = 1'b0;
    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;

    //          fetch we    size   sgn   addr           wdata          expected       lat
    vecs[0]  = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0513, 5);
    vecs[1]  = mk(1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'h0,         32'hFFFF_FF80, 2);
    vecs[2]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_0080, 2);
    vecs[3]  = mk(1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_0201, 32'h0,         32'hFFFF_FFFE, 3);
    vecs[4]  = mk(1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h0,         32'h0000_FFFE, 3);
    vecs[5]  = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,         4);
    vecs[6]  = mk(1'b0, 1'b0, 2'd2, 1'b1, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 5);
    vecs[7]  = mk(1'b0, 1'b0, 2'd3, 1'b0, 32'h0000_0301, 32'h0,         32'h11DE_ADBE, 5);
    vecs[8]  = mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_03FE, 32'h1234_ABCD, 32'h0,         2);
    vecs[9]  = mk(1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_03FE, 32'h0,         32'hFFFF_ABCD, 3);
    vecs[10] = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_03FF, 32'hAAAA_AA7F, 32'h0,         1);
    vecs[11] = mk(1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_03FE, 32'h0,         32'hFFFF_FFCD, 2);
    vecs[12] = mk(1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_03FE, 32'h0,         32'h0000_7FCD, 3);
    vecs[13] = mk(1'b0, 1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_5A7F, 3);
    vecs[14] = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 5);

    tick();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_readies", {30'b0, if_ready, ls_ready}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);

    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h00); poke(10'h103, 8'h00);
    poke(10'h200, 8'h80); poke(10'h201, 8'hFE); poke(10'h202, 8'hFF);
    poke(10'h304, 8'h11); poke(10'h000, 8'h5A);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    chk("ram_300", {24'b0, ram[10'h300]}, 32'h0000_00EF);
    chk("ram_301", {24'b0, ram[10'h301]}, 32'h0000_00BE);
    chk("ram_302", {24'b0, ram[10'h302]}, 32'h0000_00AD);
    chk("ram_303", {24'b0, ram[10'h303]}, 32'h0000_00DE);
    chk("ram_3fe", {24'b0, ram[10'h3FE]}, 32'h0000_00CD);
    chk("ram_3ff", {24'b0, ram[10'h3FF]}, 32'h0000_007F);

    // simultaneous requests: load first, fetch accepted after DONE, reqs held through DONE
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b0; ls_addr = 32'h200;
    e.src_ls = 1'b1; e.has_data = 1'b1; e.data = 32'h0000_0080; sb_q.push_back(e);
    e.src_ls = 1'b0; e.has_data = 1'b1; e.data = 32'h0000_0513; sb_q.push_back(e);
    r0 = rdy_cnt;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (j == 0) chk("arb_ls_first", mem_a, 32'h200);
      if (j == 2) chk("arb_ls_ready", {31'b0, ls_ready}, 32'd1);
      if (j == 3) begin
        chk("arb_ls_pulse", {31'b0, ls_ready}, 32'd0);
        ls_req = 1'b0;
      end
      if (j == 4) chk("arb_fetch_accept", mem_a, 32'h100);
      if (j == 9) chk("arb_if_ready", {31'b0, if_ready}, 32'd1);
      if (j == 10) begin
        chk("arb_if_pulse", {31'b0, if_ready}, 32'd0);
        if_req = 1'b0;
      end
    end
    chk("arb_pulse_count", 32'(rdy_cnt - r0), 32'd2);
    chk("arb_sb_drained", 32'(sb_q.size()), 32'd0);

    // flush in the third cycle of a fetch aborts it
    if_req = 1'b1; if_addr = 32'h100;
    r0 = rdy_cnt;
    tick(); tick(); tick();
    if_flush = 1'b1;
    tick();
    chk("flush_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("flush_mem_a_hold", mem_a, 32'h102);
    if_req = 1'b0; if_flush = 1'b0;
    repeat (8) tick();
    chk("flush_no_ready", 32'(rdy_cnt - r0), 32'd0);

    // fetch request ignored while flush is high
    if_req = 1'b1; if_addr = 32'h140; if_flush = 1'b1;
    repeat (3) tick();
    chk("flush_block_mem_a", mem_a, 32'h102);
    chk("flush_block_ready", 32'(rdy_cnt - r0), 32'd0);
    if_req = 1'b0; if_flush = 1'b0;
    tick();
    run_vec(vecs[1], 101);

    // reset in the middle of a word store
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'h0102_0304;
    r0 = rdy_cnt;
    tick();
    chk("rstmid_wr_b0", {31'b0, mem_wr}, 32'd1);
    tick();
    chk("rstmid_mem_a_b1", mem_a, 32'h301);
    chk("rstmid_dout_b1", {24'b0, mem_dout}, 32'h0000_0003);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rstmid_mem_a", mem_a, 32'd0);
    chk("rstmid_ls_ready", {31'b0, ls_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1; ls_req = 1'b0; ls_we = 1'b0;
    repeat (6) tick();
    chk("rstmid_no_ready", 32'(rdy_cnt - r0), 32'd0);
    chk("rstmid_ram_300", {24'b0, ram[10'h300]}, 32'h0000_0004);
    chk("rstmid_ram_301", {24'b0, ram[10'h301]}, 32'h0000_00BE);
    chk("rstmid_ram_302", {24'b0, ram[10'h302]}, 32'h0000_00AD);
    run_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbiter and sequencer for the single byte-wide RAM/IO port.
- Shares the port between two requesters: the instruction fetcher (word reads) and the store/load buffer (LB/LBU/LH/LHU/LW reads, SB/SH/SW writes).
- Serialises each request into byte accesses, assembles or sign-extends read data, and returns a one-cycle ready pulse to the requester.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM port.
- DATA_W, 32, requester data width; must be 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetcher request; held until if_ready is seen.
- if_addr  input  ADDR_W  fetch address.
- if_flush  input  1  misprediction flush; aborts or blocks fetch.
- if_ready  output  1  one-cycle pulse: if_data valid.
- if_data  output  32  fetched instruction word.
- ls_req  input  1  store/load buffer request; held until ls_ready.
- ls_we  input  1  1 = store, 0 = load.
- ls_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- ls_signed  input  1  sign-extend load (LB/LH).
- ls_addr  input  ADDR_W  access address.
- ls_wdata  input  32  store data; low bytes are used.
- ls_ready  output  1  one-cycle pulse: load data valid or store complete.
- ls_rdata  output  32  extended load data.
- io_buffer_full  input  1  UART buffer full; used only with the optional feature.
- mem_din  input  8  RAM read byte, valid one cycle after address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_W  RAM byte address.
- mem_wr  output  1  1 = write.

Behaviour:
- Reset (asynchronous, rst low): state IDLE, cnt=0, mem_a=0, mem_dout=0, mem_wr=0, if_ready=0, ls_ready=0, if_data=0, ls_rdata=0. A reset mid-transaction drops it immediately; no ready pulse follows.
- States: IDLE, RD, WR, DONE. All mem_* and ready outputs are registered.
- Arbitration (IDLE only):
  - ls_req wins over if_req.
  - if_req is ignored in any cycle where if_flush=1.
  - The accepted source, address, size, signedness and wdata are latched at the accept edge E0.
- N = bytes: 1, 2 or 4; a fetch is always 4, unsigned.
- Read (RD):
  - mem_a = addr+k from edge Ek, k=0..N-1; mem_wr=0.
  - mem_din for byte k is captured at edge E(k+2); byte 0 is the LSB (little-endian).
  - At E(N+1): result is assembled, zero- or sign-extended per ls_signed/size, written to if_data or ls_rdata, the matching ready is set, and the state goes to DONE.
  - Latency from accept: byte 2 edges, half 3, word 5.
- Write (WR):
  - From edge Ek, k=0..N-1: mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - At E(N): mem_wr=0, ls_ready=1, state goes to DONE.
- DONE:
  - Ready is high for exactly this cycle, then cleared; the state returns to IDLE.
  - No request is sampled in DONE, so a requester dropping req after seeing ready is never double-served.
- Address arithmetic wraps modulo 2^ADDR_W. Misaligned addresses are legal (byte-serial access).
- Idle port: mem_a holds its last value; mem_wr=0.
- if_flush during an RD serving the fetcher: abort at the next edge (state IDLE, mem_wr=0, no if_ready). Store/load transactions are unaffected by flush.
- Simultaneous if_req and ls_req: the store/load is served first; the fetch is accepted in the first IDLE cycle after that DONE.
- At most one transaction is in flight. No output other than the selected ready toggles for the other requester.

Optional Feature:
- MEM_IO_STALL_EN defined: in WR, when the current byte address has addr[17:16]==2'b11 and io_buffer_full=1 at the edge, the block does not advance.
  - mem_wr=0 during the hold; cnt is unchanged.
  - The byte is reissued once io_buffer_full=0.
  - Reads are never stalled.
- Undefined: io_buffer_full is ignored; writes always complete in N cycles.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a 0x100..0x103 on consecutive cycles; if_ready pulses 5 edges after accept with if_data=0x00000513; then idle, mem_wr=0.
- Signed loads: LB at 0x200 holding 0x80 -> ls_rdata=0xFFFFFF80 at edge 2. LBU same address -> 0x00000080. LH at 0x201 (bytes 0xFE,0xFF) -> 0xFFFFFFFE at edge 3.
- Store word: ls_we=1, size=2, addr=0x300, wdata=0xDEADBEEF -> writes 0xEF,0xBE,0xAD,0xDE to 0x300..0x303 with mem_wr=1 for 4 cycles; ls_ready one cycle after the last byte.
- Arbitration: if_req and ls_req rise together -> load served first; fetch accepted after the DONE cycle; each ready is a single-cycle pulse with no duplicate service while req stays high through DONE.
- Flush/reset: if_flush at the third cycle of a fetch -> no if_ready, state IDLE next edge. Assert rst low mid-SW -> mem_wr=0 immediately, no ls_ready.
- With MEM_IO_STALL_EN: SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles; byte written on the cycle after the flag clears; ls_ready follows one cycle later.
